// File: rtl/rv32_mem_pkg.sv
// rtl/rv32_mem_pkg.sv - shared RV32I memory-access definitions
// Purpose: funct3 encodings, dmem_ctrl FSM states and the load lane-select /
// extend function that is also used by the core's forwarding logic.
package rv32_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Select the addressed byte/halfword lane of a little-endian word and
  // sign- or zero-extend it according to the load funct3.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  funct3,
                                              input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [4:0]  sh;
    sh = {lane, 3'b000};
    b  = word[sh +: 8];
    h  = lane[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    return {{24{b[7]}}, b};
      F3_H:    return {{16{h[15]}}, h};
      F3_BU:   return {24'h0, b};
      F3_HU:   return {16'h0, h};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port word RAM with synchronous read
// Ports: clk; re (read enable, rdata updates on posedge); we (write enable);
// addr (word address); wdata (write word); rdata (registered read word).
// Contents are not reset; rdata holds its value while re is low.
module dmem_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          re,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - RV32I data-memory responder (byte/half/word, RMW stores)
// Ports: clk, rst (async, active-high); req_valid/req_ready handshake with
// req_wen, req_funct3, req_addr (byte address), req_wdata; rsp_valid/rsp_ready
// handshake with rsp_rdata (load result, else 0) and rsp_err (misaligned or
// illegal funct3). One request outstanding at a time.
module dmem_ctrl
  import rv32_mem_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int WORD_AW = ADDR_W - 2;

  state_t              state_q, state_d;
  logic                run_q;
  logic                cap_wen;
  logic [2:0]          cap_f3;
  logic [ADDR_W-1:0]   cap_addr;
  logic [31:0]         cap_wdata;
  logic                err_q;

  logic                req_legal, req_aligned, req_err;
  logic                arr_re, arr_we;
  logic [31:0]         arr_rdata, merged;

  dmem_array #(
    .DEPTH (1 << WORD_AW)
  ) u_array (
    .clk   (clk),
    .re    (arr_re),
    .we    (arr_we),
    .addr  (cap_addr[ADDR_W-1:2]),
    .wdata (merged),
    .rdata (arr_rdata)
  );

  // Decode the incoming request while IDLE so the first transition already
  // knows whether to skip the array (error) or the read (SW).
  always_comb begin
    req_legal   = 1'b0;
    req_aligned = 1'b1;
    case (req_funct3)
      F3_B, F3_H, F3_W: req_legal = 1'b1;
      F3_BU, F3_HU:     req_legal = ~req_wen;
      default:          req_legal = 1'b0;
    endcase
    case (req_funct3)
      F3_H, F3_HU: req_aligned = ~req_addr[0];
      F3_W:        req_aligned = (req_addr[1:0] == 2'b00);
      default:     req_aligned = 1'b1;
    endcase
    req_err = ~(req_legal & req_aligned);
  end

  // Store word: SW writes wdata directly; SB/SH replace one lane of the
  // word fetched in READ (arr_rdata is held through WRITE since re is low).
  always_comb begin
    merged = arr_rdata;
    case (cap_f3)
      F3_B: merged[{cap_addr[1:0], 3'b000} +: 8] = cap_wdata[7:0];
      F3_H: begin
        if (cap_addr[1]) merged[31:16] = cap_wdata[15:0];
        else             merged[15:0]  = cap_wdata[15:0];
      end
      default: merged = cap_wdata;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    arr_re    = 1'b0;
    arr_we    = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = run_q;
        if (req_valid && run_q) begin
          if (req_err)                         state_d = RESP;
          else if (req_wen && req_funct3 == F3_W) state_d = WRITE;
          else                                 state_d = READ;
        end
      end
      READ: begin
        arr_re  = 1'b1;
        state_d = cap_wen ? WRITE : RESP;
      end
      WRITE: begin
        arr_we  = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Load data is formatted straight from the RAM output register, which is
  // stable for the whole RESP phase.
  always_comb begin
    rsp_rdata = 32'h0;
    if (state_q == RESP && !cap_wen && !err_q)
      rsp_rdata = load_extend(arr_rdata, cap_f3, cap_addr[1:0]);
  end

  assign rsp_err = (state_q == RESP) & err_q;

  // run_q keeps req_ready low while rst is high and for the first edge after
  // release; rst itself never enters the combinational logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      run_q     <= 1'b0;
      cap_wen   <= 1'b0;
      cap_f3    <= 3'b000;
      cap_addr  <= '0;
      cap_wdata <= 32'h0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      if (state_q == IDLE && req_valid && run_q) begin
        cap_wen   <= req_wen;
        cap_f3    <= req_funct3;
        cap_addr  <= req_addr;
        cap_wdata <= req_wdata;
        err_q     <= req_err;
      end
    end
  end

endmodule
